// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with an internal byte FIFO.
// Per-frame configurable data bits (5-8), parity (none/odd/even/mark) and
// 1 or 2 stop bits; the configuration and baud divider are latched at frame start.
// Optional feature: define UART_TX_CTS_EN to add the active-low n_cts_in
// flow-control input. It gates the start of new frames only.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 32,
    parameter int CNT_W      = 5
) (
    input  logic             clk_in,
    input  logic             n_reset_in,
    input  logic             enable_in,
    input  logic             wr_en_in,
    input  logic [7:0]       data_in,
    input  logic [3:0]       d_num_in,
    input  logic             s_num_in,
    input  logic [1:0]       parity_in,
    input  logic [DIV_W-1:0] clk_div_baud_in,
`ifdef UART_TX_CTS_EN
    input  logic             n_cts_in,
`endif
    output logic             tx_out,
    output logic             tx_rdy_out,
    output logic             busy_out,
    output logic [CNT_W-1:0] fifo_count_out,
    output logic             overflow_out
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t state_q, state_d;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_d;
    logic             fifo_full, fifo_empty, push, pop, cts_ok, can_start;

    logic [DIV_W-1:0] div_q, bit_cnt_q, div_eff;
    logic [3:0]       n_q, n_eff;
    logic [1:0]       par_q;
    logic             stop2_q, stop_idx_q, par_bit_q, par_bit_d;
    logic [2:0]       data_idx_q;
    logic [7:0]       shreg_q, head, head_masked;
    logic             bit_end, last_data, tx_d, busy_d;

`ifdef UART_TX_CTS_EN
    assign cts_ok = ~n_cts_in;
`else
    assign cts_ok = 1'b1;
`endif

    assign fifo_full  = (fifo_count_out == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (fifo_count_out == '0);
    assign push       = wr_en_in && !fifo_full;
    assign can_start  = enable_in && !fifo_empty && cts_ok;
    assign head       = mem[rd_ptr_q];
    assign bit_end    = (bit_cnt_q == div_q - DIV_W'(1));
    assign last_data  = ({1'b0, data_idx_q} == n_q - 4'd1);

    // Frame configuration as it would be latched at this edge (clamped/defaulted)
    always_comb begin
        n_eff       = ((d_num_in >= 4'd5) && (d_num_in <= 4'd8)) ? d_num_in : 4'd8;
        div_eff     = (clk_div_baud_in < DIV_W'(2)) ? DIV_W'(2) : clk_div_baud_in;
        head_masked = head & (8'hFF >> (4'd8 - n_eff));
        case (parity_in)
            2'b01:   par_bit_d = ~(^head_masked);
            2'b10:   par_bit_d = ^head_masked;
            default: par_bit_d = 1'b1;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_in) begin
        if (!n_reset_in) state_q <= IDLE;
        else             state_q <= state_d;
    end

    // Next-state, pop decision and next line/busy values
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        tx_d    = tx_out;
        busy_d  = busy_out;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (can_start) begin
                    pop     = 1'b1;
                    state_d = START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shreg_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (!last_data) begin
                        tx_d = shreg_q[1];
                    end else if (par_q != 2'b00) begin
                        state_d = PARITY;
                        tx_d    = par_bit_q;
                    end else begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_end && (stop_idx_q == stop2_q)) begin
                    if (can_start) begin
                        pop     = 1'b1;
                        state_d = START;
                        tx_d    = 1'b0;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Next FIFO occupancy from this edge's push/pop
    always_comb begin
        case ({push, pop})
            2'b10:   count_d = fifo_count_out + CNT_W'(1);
            2'b01:   count_d = fifo_count_out - CNT_W'(1);
            default: count_d = fifo_count_out;
        endcase
    end

    // FIFO storage; not reset, only entries between the pointers are meaningful
    always_ff @(posedge clk_in) begin
        if (push) mem[wr_ptr_q] <= data_in;
    end

    // FIFO pointers, occupancy, ready and sticky overflow
    always_ff @(posedge clk_in) begin
        if (!n_reset_in) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            fifo_count_out <= '0;
            tx_rdy_out     <= 1'b1;
            overflow_out   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            fifo_count_out <= count_d;
            tx_rdy_out     <= (count_d != CNT_W'(FIFO_DEPTH));
            if (wr_en_in && fifo_full) overflow_out <= 1'b1;
        end
    end

    // Frame datapath: config latch on pop, bit timer, data shifter, stop counter
    always_ff @(posedge clk_in) begin
        if (!n_reset_in) begin
            tx_out     <= 1'b1;
            busy_out   <= 1'b0;
            div_q      <= DIV_W'(2);
            bit_cnt_q  <= '0;
            n_q        <= 4'd8;
            par_q      <= 2'b00;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            data_idx_q <= '0;
            shreg_q    <= '0;
            par_bit_q  <= 1'b0;
        end else begin
            tx_out   <= tx_d;
            busy_out <= busy_d;
            if (pop) begin
                div_q      <= div_eff;
                n_q        <= n_eff;
                par_q      <= parity_in;
                stop2_q    <= s_num_in;
                shreg_q    <= head;
                par_bit_q  <= par_bit_d;
                bit_cnt_q  <= '0;
                data_idx_q <= '0;
                stop_idx_q <= 1'b0;
            end else if (state_q != IDLE) begin
                bit_cnt_q <= bit_end ? '0 : bit_cnt_q + DIV_W'(1);
                if (bit_end && (state_q == DATA)) begin
                    data_idx_q <= data_idx_q + 3'd1;
                    shreg_q    <= shreg_q >> 1;
                end
                if (bit_end && (state_q == STOP)) stop_idx_q <= ~stop_idx_q;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo.
// Expected frames (line bit sequence start..stop, bit period, gap rule) are
// queued when a byte is written; a line monitor decodes every frame on tx_out
// and compares it against the head of that queue.
module tb_uart_tx_fifo;

    localparam int DIV_W = 32;
    localparam int CNT_W = 5;
    localparam int DEPTH = 16;

    logic             clk_in = 1'b0;
    logic             n_reset_in, enable_in, wr_en_in, s_num_in;
    logic [7:0]       data_in;
    logic [3:0]       d_num_in;
    logic [1:0]       parity_in;
    logic [DIV_W-1:0] clk_div_baud_in;
`ifdef UART_TX_CTS_EN
    logic             n_cts_in;
`endif
    logic             tx_out, tx_rdy_out, busy_out, overflow_out;
    logic [CNT_W-1:0] fifo_count_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          div;
        bit          b2b;
        int          cut;
    } frame_t;

    frame_t exp_q[$];

    uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .clk_in          (clk_in),
        .n_reset_in      (n_reset_in),
        .enable_in       (enable_in),
        .wr_en_in        (wr_en_in),
        .data_in         (data_in),
        .d_num_in        (d_num_in),
        .s_num_in        (s_num_in),
        .parity_in       (parity_in),
        .clk_div_baud_in (clk_div_baud_in),
`ifdef UART_TX_CTS_EN
        .n_cts_in        (n_cts_in),
`endif
        .tx_out          (tx_out),
        .tx_rdy_out      (tx_rdy_out),
        .busy_out        (busy_out),
        .fifo_count_out  (fifo_count_out),
        .overflow_out    (overflow_out)
    );

    // 10 ns system clock
    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(negedge clk_in);
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_frame(input logic [15:0] bits, input int nbits, input int div,
                              input bit b2b, input int cut);
        frame_t f;
        f.bits = bits; f.nbits = nbits; f.div = div; f.b2b = b2b; f.cut = cut;
        exp_q.push_back(f);
    endtask

    // Drive one write with its frame configuration; returns just after the write edge
    task automatic apply_stimulus(input logic [7:0] b, input int div, input logic [3:0] dn,
                                  input logic sn, input logic [1:0] par);
        data_in         = b;
        clk_div_baud_in = DIV_W'(div);
        d_num_in        = dn;
        s_num_in        = sn;
        parity_in       = par;
        wr_en_in        = 1'b1;
        tick();
        wr_en_in        = 1'b0;
    endtask

    // Count consecutive cycles with busy_out high, starting at the current sample
    task automatic measure_busy(output int cyc);
        cyc = 0;
        for (int i = 0; i < 2000; i++) begin
            if (busy_out !== 1'b1) break;
            cyc++;
            tick();
        end
    endtask

    // Line monitor: detect start bits, check every bit value and duration
    initial begin : monitor
        logic   prev;
        int     gap, cyc, fnum;
        bit     done, bit_ok;
        logic   seen;
        frame_t e;
        prev = 1'b1; gap = 0; fnum = 0;
        forever begin
            tick();
            if (tx_out === 1'b0 && prev === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL unexpected_frame got start bit want idle line");
                    prev = tx_out;
                end else begin
                    e = exp_q.pop_front();
                    if (e.b2b) begin
                        checks++;
                        if (gap != 0) begin
                            errors++;
                            $display("[TB] FAIL frame%0d_gap got %0d want 0", fnum, gap);
                        end
                    end
                    cyc = 1; done = 0;
                    for (int k = 0; k < e.nbits && !done; k++) begin
                        bit_ok = 1; seen = e.bits[k];
                        for (int c = 0; c < e.div && !done; c++) begin
                            if (!(k == 0 && c == 0)) begin
                                tick();
                                cyc++;
                            end
                            if (tx_out !== e.bits[k]) begin
                                bit_ok = 0;
                                seen = tx_out;
                            end
                            if (e.cut != 0 && cyc >= e.cut) done = 1;
                        end
                        checks++;
                        if (!bit_ok) begin
                            errors++;
                            $display("[TB] FAIL frame%0d_bit%0d got %b want %b", fnum, k, seen, e.bits[k]);
                        end
                    end
                    fnum++;
                    prev = tx_out;
                    gap  = 0;
                end
            end else begin
                gap++;
                prev = tx_out;
            end
        end
    end

    // Absolute time limit so the run always ends
    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence
    initial begin : stimulus
        int          cyc;
        bit          saw_low;
        logic [15:0] cfg_exp [3];
        logic [1:0]  cfg_par [3];
        logic [7:0]  tbl [17];

        cfg_exp = '{16'h07EA, 16'h06EA, 16'h07EA};
        cfg_par = '{2'b10, 2'b01, 2'b11};
        tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                8'hFF, 8'h00, 8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h0F, 8'hF0, 8'hEE};

        n_reset_in = 1'b0; enable_in = 1'b0; wr_en_in = 1'b0; data_in = 8'h00;
        d_num_in = 4'd8; s_num_in = 1'b0; parity_in = 2'b00; clk_div_baud_in = DIV_W'(4);
`ifdef UART_TX_CTS_EN
        n_cts_in = 1'b0;
`endif
        repeat (3) tick();
        $display("[TB] reset state");
        check_output("reset_tx", tx_out, 1);
        check_output("reset_rdy", tx_rdy_out, 1);
        check_output("reset_busy", busy_out, 0);
        check_output("reset_count", fifo_count_out, 0);
        check_output("reset_ovf", overflow_out, 0);
        n_reset_in = 1'b1;
        tick();

        $display("[TB] single 8N1 frame, div 4, byte 75");
        enable_in = 1'b1;
        push_frame(16'h02EA, 10, 4, 0, 0);
        apply_stimulus(8'h75, 4, 4'd8, 1'b0, 2'b00);
        check_output("lat_count_after_write", fifo_count_out, 1);
        check_output("lat_tx_still_idle", tx_out, 1);
        tick();
        check_output("lat_start_bit", tx_out, 0);
        check_output("lat_count_popped", fifo_count_out, 0);
        check_output("lat_busy", busy_out, 1);
        measure_busy(cyc);
        check_output("frame_len_8n1", cyc, 40);
        repeat (2) tick();

        $display("[TB] 7-bit, 2 stop, even/odd/mark parity, div 3");
        for (int m = 0; m < 3; m++) begin
            push_frame(cfg_exp[m], 11, 3, 0, 0);
            apply_stimulus(8'h75, 3, 4'd7, 1'b1, cfg_par[m]);
            tick();
            check_output($sformatf("cfg%0d_start", m), tx_out, 0);
            measure_busy(cyc);
            check_output($sformatf("cfg%0d_frame_len", m), cyc, 33);
            tick();
        end

        $display("[TB] divider change mid-frame, push+pop, clamp");
        push_frame(16'h02EA, 10, 4, 0, 0);
        push_frame(16'h0346, 10, 8, 1, 0);
        apply_stimulus(8'h75, 4, 4'd8, 1'b0, 2'b00);
        data_in  = 8'hA3;
        wr_en_in = 1'b1;
        tick();
        wr_en_in = 1'b0;
        check_output("push_pop_count", fifo_count_out, 1);
        check_output("push_pop_tx", tx_out, 0);
        clk_div_baud_in = DIV_W'(8);
        measure_busy(cyc);
        check_output("frame_len_div_change", cyc, 120);
        tick();
        push_frame(16'h02B4, 10, 2, 0, 0);
        apply_stimulus(8'h5A, 0, 4'd15, 1'b0, 2'b00);
        tick();
        check_output("clamp_start", tx_out, 0);
        measure_busy(cyc);
        check_output("frame_len_clamp", cyc, 20);
        tick();

        $display("[TB] fill FIFO with enable low, overflow, back-to-back drain");
        enable_in = 1'b0;
        clk_div_baud_in = DIV_W'(2);
        d_num_in = 4'd8; s_num_in = 1'b0; parity_in = 2'b00;
        for (int i = 0; i < 17; i++) begin
            data_in  = tbl[i];
            wr_en_in = 1'b1;
            if (i < 16) push_frame({5'b0, 1'b1, tbl[i], 1'b0}, 10, 2, (i > 0), 0);
            tick();
            if (i == 14) begin
                check_output("fill15_count", fifo_count_out, 15);
                check_output("fill15_rdy", tx_rdy_out, 1);
            end
            if (i == 15) begin
                check_output("fill16_count", fifo_count_out, 16);
                check_output("fill16_rdy", tx_rdy_out, 0);
                check_output("fill16_ovf", overflow_out, 0);
            end
            if (i == 16) begin
                check_output("fill17_count", fifo_count_out, 16);
                check_output("fill17_ovf", overflow_out, 1);
                check_output("fill17_tx_idle", tx_out, 1);
            end
        end
        wr_en_in  = 1'b0;
        enable_in = 1'b1;
        tick();
        check_output("drain_first_pop_count", fifo_count_out, 15);
        check_output("drain_first_pop_rdy", tx_rdy_out, 1);
        check_output("drain_first_start", tx_out, 0);
        repeat (19) tick();
        check_output("drain_count_before_pop2", fifo_count_out, 15);
        tick();
        check_output("drain_count_after_pop2", fifo_count_out, 14);
        for (int i = 0; i < 1000; i++) begin
            if (busy_out === 1'b0) break;
            tick();
        end
        check_output("drain_busy_done", busy_out, 0);
        check_output("drain_count_zero", fifo_count_out, 0);
        check_output("drain_ovf_sticky", overflow_out, 1);
        tick();

        $display("[TB] reset during data bit 3");
        push_frame(16'h02EA, 10, 4, 0, 17);
        apply_stimulus(8'h75, 4, 4'd8, 1'b0, 2'b00);
        data_in  = 8'h11;
        wr_en_in = 1'b1;
        tick();
        data_in  = 8'h22;
        tick();
        wr_en_in = 1'b0;
        check_output("pre_reset_count", fifo_count_out, 2);
        repeat (15) tick();
        check_output("pre_reset_data_bit3", tx_out, 0);
        n_reset_in = 1'b0;
        tick();
        n_reset_in = 1'b1;
        check_output("mid_reset_tx", tx_out, 1);
        check_output("mid_reset_count", fifo_count_out, 0);
        check_output("mid_reset_ovf", overflow_out, 0);
        check_output("mid_reset_busy", busy_out, 0);
        check_output("mid_reset_rdy", tx_rdy_out, 1);
        saw_low = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx_out !== 1'b1) saw_low = 1;
        end
        check_output("idle_after_reset", saw_low, 0);

`ifdef UART_TX_CTS_EN
        $display("[TB] clear-to-send gating");
        n_cts_in = 1'b1;
        push_frame(16'h02EA, 10, 4, 0, 0);
        apply_stimulus(8'h75, 4, 4'd8, 1'b0, 2'b00);
        repeat (5) tick();
        check_output("cts_hold_tx", tx_out, 1);
        check_output("cts_hold_count", fifo_count_out, 1);
        n_cts_in = 1'b0;
        tick();
        check_output("cts_release_start", tx_out, 0);
        data_in  = 8'h5A;
        wr_en_in = 1'b1;
        n_cts_in = 1'b1;
        tick();
        wr_en_in = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (busy_out === 1'b0) break;
            tick();
        end
        check_output("cts_frame_done", busy_out, 0);
        repeat (5) tick();
        check_output("cts_next_held_tx", tx_out, 1);
        check_output("cts_next_held_count", fifo_count_out, 1);
        push_frame(16'h02B4, 10, 4, 0, 0);
        n_cts_in = 1'b0;
        tick();
        check_output("cts_second_start", tx_out, 0);
        for (int i = 0; i < 200; i++) begin
            if (busy_out === 1'b0) break;
            tick();
        end
        check_output("cts_second_done", busy_out, 0);
`endif

        repeat (5) tick();
        check_output("scoreboard_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Parametrised successor to the single-byte UART transmitter: serialises bytes from an internal write FIFO onto tx_out.
- Per-frame configurable data bits (5-8), parity mode (none/odd/even/mark) and 1 or 2 stop bits.
- Sits between the host write bus and the serial pin in the UART library; pairs with the receive path.

Parameters:
- FIFO_DEPTH, 16, number of byte entries; must be a power of 2, at least 2.
- DIV_W, 32, width of the baud divider input.
- CNT_W, 5, width of fifo_count_out; must be at least log2(FIFO_DEPTH)+1.

Ports:
- clk_in  input  1  system clock; all logic is on the rising edge.
- n_reset_in  input  1  synchronous, active-low reset.
- enable_in  input  1  1 = start new frames; 0 = hold off after the current frame.
- wr_en_in  input  1  write strobe, active high; one byte per cycle.
- data_in  input  8  byte to enqueue; bit 0 is sent first.
- d_num_in  input  4  data bits per frame, 5..8.
- s_num_in  input  1  0 = 1 stop bit, 1 = 2 stop bits.
- parity_in  input  2  00 none, 01 odd, 10 even, 11 mark (always 1).
- clk_div_baud_in  input  DIV_W  clk_in cycles per bit.
- tx_out  output  1  serial line, idle high, registered.
- tx_rdy_out  output  1  FIFO not full.
- busy_out  output  1  a frame is in progress.
- fifo_count_out  output  CNT_W  number of bytes queued, excluding the frame being sent.
- overflow_out  output  1  sticky flag: a write was dropped.

Behaviour:
- Reset (n_reset_in = 0 at a rising edge): FIFO flushed; FSM goes to IDLE. Register values after that edge: tx_out = 1, tx_rdy_out = 1, busy_out = 0, fifo_count_out = 0, overflow_out = 0.
- Reset during a frame aborts it immediately. The line returns high after the reset edge; there is no partial stop bit.
- FIFO write:
  - wr_en_in = 1 and not full: data_in is enqueued at that edge.
  - wr_en_in = 1 and full: the write is dropped and overflow_out is set. This applies even if a pop happens on the same edge.
  - Writes are accepted regardless of enable_in.
- fifo_count_out and tx_rdy_out are registered and reflect the state after each edge.
- A simultaneous push and pop on a non-full FIFO leaves the count unchanged.
- Baud timing:
  - A bit counter runs 0..div-1. Each bit lasts exactly div cycles.
  - div = clk_div_baud_in, clamped to 2 if the input is below 2.
  - div, d_num_in, s_num_in and parity_in are latched at frame start. Mid-frame changes take effect on the next frame.
- d_num_in outside 5..8 is treated as 8.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if enable_in = 1 and the FIFO is not empty, pop the head, latch the config, set busy_out = 1, go to START. tx_out = 0 after this edge.
  - START: after div cycles, go to DATA and drive data bit 0.
  - DATA: shift out bits 0..n-1, LSB first, each for div cycles. After the last bit, go to PARITY if parity is enabled, else STOP.
  - PARITY: drive the parity bit for div cycles. Odd/even parity is computed over the n active bits only. Mark = 1.
  - STOP: tx_out = 1 for div cycles (1 stop) or 2*div cycles (2 stop). At the end:
    - if enable_in = 1 and the FIFO is not empty, pop on the same edge and go straight to START (back-to-back frames, no idle gap);
    - otherwise go to IDLE with busy_out = 0.
- Latency: a write at edge E into an empty FIFO with the FSM in IDLE and enable_in = 1 gives tx_out = 0 after edge E+1. fifo_count_out reads 1 for exactly one cycle.
- enable_in going low mid-frame has no effect on that frame.
- Frame length in cycles: div * (1 + n + p + s), where n = data bits, p = 1 if parity is enabled else 0, s = number of stop bits.
- overflow_out clears only on reset.

Optional Feature:
- Macro: UART_TX_CTS_EN.
- Defined: adds input port n_cts_in (1 bit, active-low clear-to-send). IDLE and the STOP-end check start a new frame only if n_cts_in = 0. A frame already in progress always completes. n_cts_in is sampled directly, with no internal synchroniser; the integrator supplies one.
- Undefined: the port is absent and the block behaves as if n_cts_in = 0.

Test Plan:
- Single frame: div = 4, 8N1, write 8'h75. tx_out low after edge E+1, then bits 1,0,1,0,1,1,1,0, then stop = 1. Each bit lasts 4 cycles; frame = 40 cycles; busy_out falls after that.
- Config modes: div = 3, d_num = 7, even parity, 2 stop, byte 8'h75 (7-bit value 0x75 has five 1s, so parity bit = 1). Frame = 3*(1+7+1+2) = 33 cycles. Repeat with odd parity (bit = 0) and mark (bit = 1).
- Back-to-back and full: enable_in = 0, write 17 bytes with FIFO_DEPTH = 16. tx_rdy_out = 0 after the 16th; the 17th is dropped and overflow_out = 1. Set enable_in = 1: 16 frames go out with no idle gap between stop and start, fifo_count_out counts down to 0.
- Reset mid-frame: assert n_reset_in during DATA bit 3. After that edge tx_out = 1, fifo_count_out = 0, overflow_out = 0, busy_out = 0. No further frames until a new write.
- Config change and clamp: change clk_div_baud_in from 4 to 8 mid-frame. The current frame stays at 4 cycles/bit; the next frame uses 8. With div = 0, each bit lasts 2 cycles.
- CTS (macro defined): n_cts_in = 1, write byte; tx_out stays high. Drop n_cts_in; the start bit follows on the next edge. Raise n_cts_in mid-frame; that frame completes and the next queued frame is held.
